// File: rtl/inner_product_result_drain.sv
// inner_product_result_drain: buffers NUM-wide result vectors and streams them one lane per beat with row/tile tags.
// Optional RESULT_SAT_EN: signed-saturate each lane to STREAM_WIDTH instead of truncating.
module inner_product_result_drain #(
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int NUM = 4,
  parameter int STREAM_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ROWS_PER_TILE = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vec_valid_in,
  input  logic [NUM*OUTPUT_DATA_WIDTH-1:0]  vec_in,
  output logic                              vec_ready_out,
  output logic                              s_valid,
  input  logic                              s_ready,
  output logic [STREAM_WIDTH-1:0]           s_data,
  output logic                              s_last_row,
  output logic                              s_last_tile,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow_err
);
  localparam int ODW = OUTPUT_DATA_WIDTH;
  localparam int SW = STREAM_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(NUM);
  localparam int RW = ROWS_PER_TILE > 1 ? $clog2(ROWS_PER_TILE) : 1;
  logic [NUM*ODW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [RW-1:0] row_q, row_d;
  logic ovf_q, ovf_d;
  logic push, beat, pop, last_lane, last_row_idx;
  logic [SW-1:0] lane_out;
`ifdef RESULT_SAT_EN
  logic [ODW-1:0] word;
  logic [ODW-SW:0] hi;
`endif
  always_comb begin
    push = vec_valid_in && count_q < CW'(FIFO_DEPTH);
    beat = s_valid && s_ready;
    last_lane = lane_q == LW'(NUM - 1);
    last_row_idx = row_q == RW'(ROWS_PER_TILE - 1);
    pop = beat && last_lane;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    lane_d = beat ? (last_lane ? '0 : lane_q + LW'(1)) : lane_q;
    row_d = pop ? (last_row_idx ? '0 : row_q + RW'(1)) : row_q;
    ovf_d = ovf_q | (vec_valid_in && !push);
`ifdef RESULT_SAT_EN
    word = mem_q[rd_ptr_q][lane_q*ODW +: ODW];
    hi = word[ODW-1:SW-1];
    // in range only when every bit above the kept sign bit matches it
    lane_out = (&hi || !(|hi)) ? word[SW-1:0] : {word[ODW-1], {(SW-1){!word[ODW-1]}}};
`else
    lane_out = mem_q[rd_ptr_q][lane_q*ODW +: SW];
`endif
  end
  assign s_valid = count_q != '0;
  assign s_data = s_valid ? lane_out : '0;
  assign s_last_row = s_valid && last_lane;
  assign s_last_tile = s_last_row && last_row_idx;
  assign fifo_count = count_q;
  assign vec_ready_out = count_q < CW'(FIFO_DEPTH);
  assign overflow_err = ovf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      lane_q <= '0;
      row_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      lane_q <= lane_d;
      row_q <= row_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= vec_in;
  end
endmodule

// File: tb/tb_inner_product_result_drain.sv
// tb_inner_product_result_drain: directed stimulus with a scoreboard queue checked by an independent stream monitor.
module tb_inner_product_result_drain;
  localparam int ODW = 32, NUM = 4, SW = 16, FD = 4, RPT = 2;
`ifdef RESULT_SAT_EN
  localparam logic [15:0] SAT_POS = 16'h7FFF, SAT_NEG = 16'h8000;
`else
  localparam logic [15:0] SAT_POS = 16'h0000, SAT_NEG = 16'h0000;
`endif
  logic clk = 1'b0;
  logic rst, vec_valid_in, s_ready, vec_ready_out, s_valid, s_last_row, s_last_tile, overflow_err;
  logic [NUM*ODW-1:0] vec_in;
  logic [SW-1:0] s_data;
  logic [$clog2(FD):0] fifo_count;
  logic [SW+1:0] exp_q [$];
  int errors = 0, checks = 0, mrow = 0;

  inner_product_result_drain #(
    .OUTPUT_DATA_WIDTH(ODW), .NUM(NUM), .STREAM_WIDTH(SW), .FIFO_DEPTH(FD), .ROWS_PER_TILE(RPT)
  ) dut (
    .clk(clk), .rst(rst), .vec_valid_in(vec_valid_in), .vec_in(vec_in),
    .vec_ready_out(vec_ready_out), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last_row(s_last_row), .s_last_tile(s_last_tile), .fifo_count(fifo_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input logic [31:0] l0, l1, l2, l3, input logic [15:0] e0, e1, e2, e3, input bit acc);
    vec_valid_in = 1'b1;
    vec_in = {l3, l2, l1, l0};
    if (acc) begin
      exp_q.push_back({e0, 1'b0, 1'b0});
      exp_q.push_back({e1, 1'b0, 1'b0});
      exp_q.push_back({e2, 1'b0, 1'b0});
      exp_q.push_back({e3, 1'b1, mrow == RPT - 1});
      mrow = (mrow + 1) % RPT;
    end
    @(posedge clk); #1;
    vec_valid_in = 1'b0;
  endtask

  task automatic push4(input logic [31:0] a, b, c, d, input bit acc);
    push_vec(a, b, c, d, a[15:0], b[15:0], c[15:0], d[15:0], acc);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    mrow = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst s_valid", 32'(s_valid), 0);
    chk("rst fifo_count", 32'(fifo_count), 0);
    chk("rst vec_ready_out", 32'(vec_ready_out), 1);
    chk("rst overflow_err", 32'(overflow_err), 0);
    chk("rst s_data", 32'(s_data), 0);
    chk("rst s_last_row", 32'(s_last_row), 0);
    chk("rst s_last_tile", 32'(s_last_tile), 0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst && s_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream beat: got data=%0h row=%0b tile=%0b expected no beat", s_data, s_last_row, s_last_tile);
      end else if ({s_data, s_last_row, s_last_tile} !== exp_q[0]) begin
        errors++;
        $display("FAIL stream beat: got data=%0h row=%0b tile=%0b expected data=%0h row=%0b tile=%0b",
                 s_data, s_last_row, s_last_tile, exp_q[0][SW+1:2], exp_q[0][1], exp_q[0][0]);
      end
      if (s_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    vec_valid_in = 1'b0;
    s_ready = 1'b0;
    vec_in = '0;
    do_reset();
    s_ready = 1'b1;
    push4(1, 2, 3, 4, 1);
    chk("t2 count after push", 32'(fifo_count), 1);
    chk("t2 s_valid", 32'(s_valid), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t2 count drained", 32'(fifo_count), 0);
    chk("t2 s_valid drained", 32'(s_valid), 0);
    s_ready = 1'b0;
    push4(32'h11, 32'h12, 32'h13, 32'h14, 1);
    push4(32'h21, 32'h22, 32'h23, 32'h24, 1);
    push4(32'h31, 32'h32, 32'h33, 32'h34, 1);
    chk("t3 ready after 3", 32'(vec_ready_out), 1);
    push4(32'h41, 32'h42, 32'h43, 32'h44, 1);
    chk("t3 ready after 4", 32'(vec_ready_out), 0);
    chk("t3 count full", 32'(fifo_count), 4);
    chk("t3 no overflow yet", 32'(overflow_err), 0);
    push4(32'h51, 32'h52, 32'h53, 32'h54, 0);
    chk("t3 overflow", 32'(overflow_err), 1);
    chk("t3 count after drop", 32'(fifo_count), 4);
    repeat (3) @(posedge clk);
    #1;
    s_ready = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("t3 count drained", 32'(fifo_count), 0);
    chk("t3 queue empty", 32'(exp_q.size()), 0);
    chk("t3 overflow sticky", 32'(overflow_err), 1);
    do_reset();
    s_ready = 1'b1;
    push4(32'h61, 32'h62, 32'h63, 32'h64, 1);
    push4(32'h71, 32'h72, 32'h73, 32'h74, 1);
    push4(32'h81, 32'h82, 32'h83, 32'h84, 1);
    push4(32'h91, 32'h92, 32'h93, 32'h94, 1);
    repeat (14) @(posedge clk);
    #1;
    chk("t4 count drained", 32'(fifo_count), 0);
    chk("t4 queue empty", 32'(exp_q.size()), 0);
    push_vec(32'h0001_0000, 32'hFFFF_0000, 32'h0000_1234, 32'h0000_0000,
             SAT_POS, SAT_NEG, 16'h1234, 16'h0000, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t5 queue empty", 32'(exp_q.size()), 0);
    s_ready = 1'b0;
    push4(32'hA1, 32'hA2, 32'hA3, 32'hA4, 1);
    push4(32'hB1, 32'hB2, 32'hB3, 32'hB4, 1);
    push4(32'hC1, 32'hC2, 32'hC3, 32'hC4, 1);
    chk("t6 backlog", 32'(fifo_count), 3);
    s_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_ready = 1'b0;
    exp_q.delete();
    mrow = 0;
    #1;
    chk("t6 async s_valid", 32'(s_valid), 0);
    chk("t6 async count", 32'(fifo_count), 0);
    @(posedge clk); #1;
    chk("t6 held s_valid", 32'(s_valid), 0);
    chk("t6 held count", 32'(fifo_count), 0);
    rst = 1'b1;
    s_ready = 1'b1;
    @(posedge clk); #1;
    push4(7, 8, 9, 10, 1);
    push4(32'h0B, 32'h0C, 32'h0D, 32'h0E, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t6 count drained", 32'(fifo_count), 0);
    chk("t6 queue empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
